// File: rtl/sipo_deserializer_framed_if.sv
// Word-side valid/ready bundle for the framed deserializer.
// master = word producer, slave = consumer.
interface sipo_deserializer_framed_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Parallel_Data_Out;
  logic             Data_Valid_Out;
  logic             Data_Ready_In;

  modport master (
    output Parallel_Data_Out,
    output Data_Valid_Out,
    input  Data_Ready_In
  );

  modport slave (
    input  Parallel_Data_Out,
    input  Data_Valid_Out,
    output Data_Ready_In
  );
endinterface

// File: rtl/sipo_deserializer_framed.sv
// Framed serial-in/parallel-out deserializer with bit order select,
// one-word holding buffer, valid/ready output and sticky overrun.
module sipo_deserializer_framed #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  input  logic                 Enable_In,
  input  logic                 Shift_Data_Signal_In,
  input  logic                 Serial_Data_In,
  input  logic                 Msb_First_In,
  input  logic                 Frame_Start_In,
  input  logic                 Overrun_Clear_In,
  sipo_deserializer_framed_if.master out_if,
  output logic                 Overrun_Out,
  output logic [CNT_W-1:0]     Bit_Count_Out
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] hold_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, ovr_q;
  logic             bit_take, frame, complete;
  logic             accept, load;

  always_comb begin
    bit_take = Enable_In & Shift_Data_Signal_In;
    frame    = Enable_In & Frame_Start_In;
    complete = bit_take & ~frame
             & (cnt_q == CNT_W'(WIDTH - 1));
    accept   = valid_q & out_if.Data_Ready_In;
    load     = complete & (~valid_q | accept);
    word     = Msb_First_In
             ? {shift_q[WIDTH-2:0], Serial_Data_In}
             : {Serial_Data_In, shift_q[WIDTH-1:1]};
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    // A strobe on a resync edge is the first bit of the new frame
    if (frame) begin
      cnt_d   = bit_take ? CNT_W'(1) : '0;
      shift_d = '0;
      if (bit_take) begin
        shift_d = Msb_First_In
                ? {{(WIDTH-1){1'b0}}, Serial_Data_In}
                : {Serial_Data_In, {(WIDTH-1){1'b0}}};
      end
    end else if (complete) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (bit_take) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = word;
    end
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load) begin
        hold_q  <= word;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (complete & valid_q & ~out_if.Data_Ready_In)
        ovr_q <= 1'b1;
      else if (Overrun_Clear_In)
        ovr_q <= 1'b0;
    end
  end

  assign out_if.Parallel_Data_Out = hold_q;
  assign out_if.Data_Valid_Out    = valid_q;
  assign Overrun_Out              = ovr_q;
  assign Bit_Count_Out            = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer_framed.sv
// Bench for sipo_deserializer_framed: vector table, directed
// corner sequences and randomized traffic against a queue model.
module tb_sipo_deserializer_framed;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk, rst, en, strb, sd, msb, fs, clr;
  logic          ovr;
  logic [CW-1:0] cnt;

  sipo_deserializer_framed_if #(.WIDTH(W)) bus ();

  sipo_deserializer_framed #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk_In               (clk),
    .Reset_In             (rst),
    .Enable_In            (en),
    .Shift_Data_Signal_In (strb),
    .Serial_Data_In       (sd),
    .Msb_First_In         (msb),
    .Frame_Start_In       (fs),
    .Overrun_Clear_In     (clr),
    .out_if               (bus.master),
    .Overrun_Out          (ovr),
    .Bit_Count_Out        (cnt)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v,
                           input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      en   = 1'b1;
      strb = 1'b1;
      sd   = v[i];
      edge_wait();
      strb = 1'b0;
    end
  endtask

  task automatic drain();
    bus.Data_Ready_In = 1'b1;
    edge_wait();
  endtask

  typedef struct {
    logic        msb;
    logic [15:0] seq;
    logic        rdy;
    logic [15:0] exp_d;
    logic        exp_v;
    logic        exp_o;
  } vec_t;

  vec_t vt[6];

  bit          mq[$];
  logic [15:0] m_hold;
  bit          m_v, m_o;

  function automatic logic [15:0] assemble(input bit m);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (m) w[W-1-i] = mq[i];
      else   w[i]     = mq[i];
    end
    return w;
  endfunction

  task automatic model_step();
    bit          take, fr, acc, cmp;
    logic [15:0] wd;
    take = en && strb;
    fr   = en && fs;
    acc  = m_v && bus.Data_Ready_In;
    cmp  = 1'b0;
    wd   = '0;
    if (fr) begin
      mq.delete();
      if (take) mq.push_back(sd);
    end else if (take) begin
      mq.push_back(sd);
      if (mq.size() == W) begin
        cmp = 1'b1;
        wd  = assemble(msb);
        mq.delete();
      end
    end
    if (cmp && m_v && !bus.Data_Ready_In) m_o = 1'b1;
    else if (clr) m_o = 1'b0;
    if (cmp && (!m_v || acc)) begin
      m_hold = wd;
      m_v    = 1'b1;
    end else if (acc) begin
      m_v = 1'b0;
    end
  endtask

  initial begin
    int nwords;
    vt[0] = '{1'b1, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b0};
    vt[1] = '{1'b0, 16'hA5C3, 1'b1, 16'hC3A5, 1'b1, 1'b0};
    vt[2] = '{1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{1'b0, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0};
    vt[4] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[5] = '{1'b0, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; strb = 1'b0; sd = 1'b0;
    msb = 1'b1; fs = 1'b0; clr = 1'b0;
    bus.Data_Ready_In = 1'b0;
    #3;
    chk("rst_data", bus.Parallel_Data_Out, 16'h0);
    chk("rst_valid", bus.Data_Valid_Out, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_cnt", cnt, 5'd0);
    #9 rst = 1'b0;
    edge_wait();

    for (int k = 0; k < 6; k++) begin
      drain();
      msb = vt[k].msb;
      bus.Data_Ready_In = vt[k].rdy;
      send_bits(vt[k].seq, 15, 0);
      chk($sformatf("vec%0d_data", k),
          bus.Parallel_Data_Out, vt[k].exp_d);
      chk($sformatf("vec%0d_valid", k),
          bus.Data_Valid_Out, vt[k].exp_v);
      chk($sformatf("vec%0d_ovr", k), ovr, vt[k].exp_o);
      chk($sformatf("vec%0d_cnt", k), cnt, 5'd0);
    end

    drain();
    msb = 1'b1;
    send_bits(16'hA5C3, 15, 0);
    chk("msb_valid_on16", bus.Data_Valid_Out, 1'b1);
    chk("msb_data", bus.Parallel_Data_Out, 16'hA5C3);
    edge_wait();
    chk("msb_valid_next", bus.Data_Valid_Out, 1'b0);
    chk("msb_cnt", cnt, 5'd0);

    bus.Data_Ready_In = 1'b0;
    send_bits(16'h1234, 15, 0);
    chk("bp_first", bus.Parallel_Data_Out, 16'h1234);
    chk("bp_first_ovr", ovr, 1'b0);
    send_bits(16'hFFFF, 15, 0);
    chk("bp_hold", bus.Parallel_Data_Out, 16'h1234);
    chk("bp_valid", bus.Data_Valid_Out, 1'b1);
    chk("bp_ovr", ovr, 1'b1);
    clr = 1'b1;
    edge_wait();
    clr = 1'b0;
    chk("bp_clr", ovr, 1'b0);
    chk("bp_clr_valid", bus.Data_Valid_Out, 1'b1);

    send_bits(16'h00FF, 15, 1);
    bus.Data_Ready_In = 1'b1;
    send_bits(16'h00FF, 0, 0);
    chk("b2b_valid", bus.Data_Valid_Out, 1'b1);
    chk("b2b_data", bus.Parallel_Data_Out, 16'h00FF);
    chk("b2b_ovr", ovr, 1'b0);

    drain();
    nwords = 0;
    for (int i = 6; i >= 0; i--) begin
      send_bits(16'h007F, i, i);
      if (bus.Data_Valid_Out) nwords++;
    end
    chk("fr_cnt7", cnt, 5'd7);
    en = 1'b1; fs = 1'b1; strb = 1'b1; sd = 1'b1;
    edge_wait();
    fs = 1'b0; strb = 1'b0;
    chk("fr_cnt1", cnt, 5'd1);
    for (int i = 14; i >= 0; i--) begin
      send_bits(16'hBEEF, i, i);
      if (bus.Data_Valid_Out) nwords++;
    end
    chk("fr_data", bus.Parallel_Data_Out, 16'hBEEF);
    edge_wait();
    if (bus.Data_Valid_Out) nwords++;
    chk("fr_words", nwords, 1);

    bus.Data_Ready_In = 1'b0;
    send_bits(16'h1111, 15, 0);
    send_bits(16'hABCD, 15, 7);
    chk("mid_cnt9", cnt, 5'd9);
    chk("mid_valid", bus.Data_Valid_Out, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_data", bus.Parallel_Data_Out, 16'h0);
    chk("mrst_valid", bus.Data_Valid_Out, 1'b0);
    chk("mrst_ovr", ovr, 1'b0);
    chk("mrst_cnt", cnt, 5'd0);
    #2 rst = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strb = 1'b1; sd = 1'b1;
      edge_wait();
    end
    strb = 1'b0;
    chk("dis_cnt", cnt, 5'd0);
    chk("dis_valid", bus.Data_Valid_Out, 1'b0);

    rst = 1'b1;
    #2 rst = 1'b0;
    mq.delete();
    m_hold = '0; m_v = 1'b0; m_o = 1'b0;
    msb = 1'b0;
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 9) != 0);
      strb = ($urandom_range(0, 3) != 0);
      sd   = 1'($urandom);
      fs   = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 9) == 0);
      bus.Data_Ready_In = 1'($urandom);
      if (mq.size() == 0 && $urandom_range(0, 5) == 0)
        msb = ~msb;
      edge_wait();
      model_step();
      chk("rnd_data", bus.Parallel_Data_Out, m_hold);
      chk("rnd_valid", bus.Data_Valid_Out, m_v);
      chk("rnd_ovr", ovr, m_o);
      chk("rnd_cnt", cnt, mq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer_framed.md
Name: sipo_deserializer_framed

Overview:
- Parametrised serial-in/parallel-out deserializer.
- Collects WIDTH serial bits into a word and presents each completed word on a holding register.
- Uses a valid/ready handshake to the downstream consumer.
- Adds over the basic SIPO: selectable bit order, frame resynchronisation, word-complete detection, one-word output buffering and a sticky overrun flag.
- Sits between a serial receive front end (bit strobe plus data) and word-oriented logic.

Parameters:
- WIDTH, 16, deserialized word width in bits; legal range 2 to 64.
- CNT_W, 5, bit counter width; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- Clk_In  input  1  clock; all state updates on the falling edge.
- Reset_In  input  1  reset; asynchronous, active-high.
- Enable_In  input  1  serial-side enable; when low, bit strobes and Frame_Start_In are ignored.
- Shift_Data_Signal_In  input  1  bit strobe; Serial_Data_In is sampled on edges where this and Enable_In are both high.
- Serial_Data_In  input  1  serial data bit.
- Msb_First_In  input  1  1 = first received bit lands in bit WIDTH-1; 0 = first received bit lands in bit 0.
- Frame_Start_In  input  1  resynchronise: discard the partial word and restart the bit count.
- Data_Ready_In  input  1  consumer ready.
- Overrun_Clear_In  input  1  clears Overrun_Out.
- Parallel_Data_Out  output  WIDTH  holding register; always driven, never Z.
- Data_Valid_Out  output  1  holding register contains an unconsumed word.
- Overrun_Out  output  1  sticky; a completed word was dropped.
- Bit_Count_Out  output  CNT_W  bits collected in the current partial word.

Behaviour:
- Reset (async, immediate): shift register, holding register, bit counter, Data_Valid_Out and Overrun_Out all go to 0. Reset mid-word discards the partial word and any held word.
- Sample condition: bit_take = Enable_In and Shift_Data_Signal_In.
- On bit_take with Msb_First_In=1: shift = {shift[WIDTH-2:0], Serial_Data_In}.
- On bit_take with Msb_First_In=0: shift = {Serial_Data_In, shift[WIDTH-1:1]}.
- Msb_First_In may only change while Bit_Count_Out = 0; the bench enforces this and the RTL need not check it.
- Bit counter increments on each bit_take and counts 0..WIDTH-1.
- Word complete = bit_take while count = WIDTH-1. On that edge:
  - count wraps to 0 and the shift register clears to 0;
  - the full word, including the current bit, is the candidate for the holding register.
- Handshake:
  - accept = Data_Valid_Out and Data_Ready_In.
  - On accept without word complete, Data_Valid_Out goes to 0.
  - Holding register and Data_Valid_Out change only at word-load or accept edges.
- Word load when word complete and (Data_Valid_Out = 0 or accept): holding gets the new word and Data_Valid_Out = 1. Simultaneous accept and complete gives back-to-back words with no bubble.
- Overrun when word complete, Data_Valid_Out = 1 and Data_Ready_In = 0:
  - the new word is dropped;
  - the holding register is unchanged;
  - Overrun_Out is set to 1.
- Overrun_Out stays 1 until an Overrun_Clear_In edge. If set and clear occur on the same edge, set wins.
- Latency: Data_Valid_Out and Parallel_Data_Out update on the same edge that samples the WIDTH-th bit (0 cycles after the last strobe edge).
- Frame_Start_In with Enable_In=1: count and shift register clear.
  - If bit_take is on the same edge, that bit becomes bit 1 of the new frame and count = 1.
  - Word complete is never signalled on a Frame_Start_In edge.
- Enable_In=0: serial side frozen (count and shift held). The handshake and overrun clear still operate.
- Bit_Count_Out reflects the registered count.

Test Plan:
- MSB-first, WIDTH=16: strobe bits of 0xA5C3 MSB first, Data_Ready_In=1.
  - Parallel_Data_Out = 0xA5C3.
  - Data_Valid_Out = 1 on the 16th edge and 0 one edge later.
  - Bit_Count_Out returns to 0.
- LSB-first: same bit sequence with Msb_First_In=0 -> Parallel_Data_Out = 0xC3A5.
- Back-pressure with Data_Ready_In=0: send 0x1234 then 0xFFFF.
  - Output holds 0x1234 with Data_Valid_Out=1 and Overrun_Out=1.
  - Pulse Overrun_Clear_In -> Overrun_Out=0.
- Simultaneous accept and complete: Data_Ready_In=1 on the edge completing a second word 0x00FF.
  - Data_Valid_Out stays 1, output = 0x00FF, Overrun_Out=0.
- Frame_Start_In after 7 bits, then 16 bits of 0xBEEF:
  - exactly one word, value 0xBEEF;
  - Frame_Start_In together with a strobe gives Bit_Count_Out=1.
- Reset mid-word after 9 bits, then Enable_In=0 with 5 strobes:
  - all outputs 0 immediately on reset;
  - count stays 0 and no valid is raised.
